// File: rtl/relobi_mux.sv
// ---------------------------------------------------------------------------
// relobi_mux
//
// Shares one reliable-OBI (relobi) manager port between NumSbrPorts
// subordinate ports. Requests are arbitrated round-robin. Up to NumMaxTrans
// granted transactions are tracked in a small FIFO of port indices, so each
// in-order response is steered back to the port that issued it.
//
// The handshake signals req/gnt/rvalid/rready are carried as 3-bit replicas.
// Every piece of control state is held three times. Each replica computes
// its own next state from its own replica bits. The three next-state values
// are majority-voted, and all three registers load the voted value. A single
// upset replica is therefore repaired at the next clock edge.
//
// Optional feature macro: RELOBI_MUX_FAULT_REPORT_EN
//   defined   : fault_o is the OR of the state-voter disagreement flags.
//               It is combinational and rises in the same cycle as the
//               disagreement.
//   undefined : fault_o is tied to 0 and no disagreement flags are built.
//
// Ports
//   clk_i            in   clock
//   rst_i            in   synchronous, active-high reset
//   sbr_ports_req_i  in   NumSbrPorts x obi_req_t, requests from requesters
//   sbr_ports_rsp_o  out  NumSbrPorts x obi_rsp_t, responses to requesters
//   mgr_port_req_o   out  obi_req_t, shared manager request
//   mgr_port_rsp_i   in   obi_rsp_t, shared manager response
//   fault_o          out  voter disagreement seen this cycle
// ---------------------------------------------------------------------------

package obi_pkg;

  typedef struct packed {
    bit          UseRReady;
    bit          Integrity;
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b1,
    Integrity: 1'b0,
    AddrWidth: 32,
    DataWidth: 32
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } relobi_a_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } relobi_r_t;

  typedef struct packed {
    relobi_a_t  a;
    logic [2:0] req;
    logic [2:0] rready;
  } relobi_req_t;

  typedef struct packed {
    relobi_r_t  r;
    logic [2:0] gnt;
    logic [2:0] rvalid;
  } relobi_rsp_t;

endpackage

module relobi_mux #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::relobi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::relobi_rsp_t,
  parameter int unsigned       NumSbrPorts = 2,
  parameter int unsigned       NumMaxTrans = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i,
  output logic     fault_o
);

  if (ObiCfg.Integrity) begin : gen_integrity_unsupported
    $fatal(1, "relobi_mux: ObiCfg.Integrity=1 is not supported");
  end
  if (NumSbrPorts < 2) begin : gen_too_few_ports
    $fatal(1, "relobi_mux: NumSbrPorts must be at least 2");
  end
  if (NumMaxTrans < 1) begin : gen_no_capacity
    $fatal(1, "relobi_mux: NumMaxTrans must be at least 1");
  end

  localparam int unsigned SelW = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1;
  localparam int unsigned IdxW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [SelW-1:0] SelLast  = SelW'(NumSbrPorts - 1);
  localparam logic [IdxW-1:0] PtrLast  = IdxW'(NumMaxTrans - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(NumMaxTrans);
  localparam logic [SelW:0]   NumPorts = (SelW + 1)'(NumSbrPorts);

  typedef logic [SelW-1:0]                  sel_t;
  typedef logic [IdxW-1:0]                  ptr_t;
  typedef logic [CntW-1:0]                  cnt_t;
  typedef logic [NumMaxTrans-1:0][SelW-1:0] fifo_t;

  // Replicated state: index [r] selects replica r.
  sel_t  [2:0] rr_q,   rr_d;
  logic  [2:0] lock_q, lock_d;
  sel_t  [2:0] lsel_q, lsel_d;
  cnt_t  [2:0] cnt_q,  cnt_d;
  ptr_t  [2:0] wptr_q, wptr_d;
  ptr_t  [2:0] rptr_q, rptr_d;
  fifo_t [2:0] fifo_q, fifo_d;

  // Voted next state, loaded into all three replicas.
  sel_t  rr_v;
  logic  lock_v;
  sel_t  lsel_v;
  cnt_t  cnt_v;
  ptr_t  wptr_v;
  ptr_t  rptr_v;
  fifo_t fifo_v;

  // Per-replica combinational decisions.
  sel_t [2:0] sel;
  sel_t [2:0] head;
  logic [2:0] blocked;
  logic [2:0] mreq;
  logic [2:0] hs;
  logic [2:0] rvld;
  logic [2:0] pop;
  logic [2:0] mgr_rready;
  sel_t       sel_v;

  // ---- Arbitration, handshake and response routing, one per replica ----
  always_comb begin
    logic           found;
    logic [SelW:0]  cand;
    for (int r = 0; r < 3; r++) begin
      found      = 1'b0;
      cand       = '0;
      blocked[r] = (cnt_q[r] == CntFull);
      sel[r]     = rr_q[r];
      if (lock_q[r]) begin
        // A request that was issued but not granted must stay on the same
        // port until it is accepted.
        sel[r] = lsel_q[r];
      end else begin
        for (int off = 0; off < int'(NumSbrPorts); off++) begin
          cand = {1'b0, rr_q[r]} + (SelW + 1)'(off);
          if (cand >= NumPorts) begin
            cand = cand - NumPorts;
          end
          if (!found && sbr_ports_req_i[cand[SelW-1:0]].req[r]) begin
            sel[r] = cand[SelW-1:0];
            found  = 1'b1;
          end
        end
      end
      mreq[r] = !blocked[r] && sbr_ports_req_i[sel[r]].req[r];
      hs[r]   = mreq[r] && mgr_port_rsp_i.gnt[r];
      head[r] = fifo_q[r][rptr_q[r]];
      // A response with nothing outstanding is a protocol error; drop it.
      rvld[r] = mgr_port_rsp_i.rvalid[r] && (cnt_q[r] != '0);
    end
  end

  if (ObiCfg.UseRReady) begin : gen_rready
    always_comb begin
      for (int r = 0; r < 3; r++) begin
        mgr_rready[r] = sbr_ports_req_i[head[r]].rready[r];
      end
    end
    assign pop = rvld & mgr_rready;
  end else begin : gen_no_rready
    assign mgr_rready = 3'b111;
    assign pop        = rvld;
  end

  // ---- Per-replica next state ----
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rr_d[r]   = rr_q[r];
      lock_d[r] = lock_q[r];
      lsel_d[r] = lsel_q[r];
      cnt_d[r]  = cnt_q[r];
      wptr_d[r] = wptr_q[r];
      rptr_d[r] = rptr_q[r];
      fifo_d[r] = fifo_q[r];

      if (mreq[r] && !mgr_port_rsp_i.gnt[r]) begin
        lock_d[r] = 1'b1;
        lsel_d[r] = sel[r];
      end

      if (hs[r]) begin
        lock_d[r]            = 1'b0;
        fifo_d[r][wptr_q[r]] = sel[r];
        wptr_d[r]            = (wptr_q[r] == PtrLast) ? '0 : wptr_q[r] + IdxW'(1);
        rr_d[r]              = (sel[r] == SelLast) ? '0 : sel[r] + SelW'(1);
      end

      if (pop[r]) begin
        rptr_d[r] = (rptr_q[r] == PtrLast) ? '0 : rptr_q[r] + IdxW'(1);
      end

      // Simultaneous push and pop leaves the count unchanged.
      unique case ({hs[r], pop[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CntW'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - CntW'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // ---- Bitwise majority voters ----
  always_comb begin
    rr_v   = (rr_d[0]   & rr_d[1])   | (rr_d[0]   & rr_d[2])   | (rr_d[1]   & rr_d[2]);
    lock_v = (lock_d[0] & lock_d[1]) | (lock_d[0] & lock_d[2]) | (lock_d[1] & lock_d[2]);
    lsel_v = (lsel_d[0] & lsel_d[1]) | (lsel_d[0] & lsel_d[2]) | (lsel_d[1] & lsel_d[2]);
    cnt_v  = (cnt_d[0]  & cnt_d[1])  | (cnt_d[0]  & cnt_d[2])  | (cnt_d[1]  & cnt_d[2]);
    wptr_v = (wptr_d[0] & wptr_d[1]) | (wptr_d[0] & wptr_d[2]) | (wptr_d[1] & wptr_d[2]);
    rptr_v = (rptr_d[0] & rptr_d[1]) | (rptr_d[0] & rptr_d[2]) | (rptr_d[1] & rptr_d[2]);
    fifo_v = (fifo_d[0] & fifo_d[1]) | (fifo_d[0] & fifo_d[2]) | (fifo_d[1] & fifo_d[2]);
    // The address/data payload follows the majority view of the selection.
    sel_v  = (sel[0] & sel[1]) | (sel[0] & sel[2]) | (sel[1] & sel[2]);
  end

`ifdef RELOBI_MUX_FAULT_REPORT_EN
  logic [6:0] vote_err;

  always_comb begin
    vote_err[0] = (rr_d[0]   != rr_d[1])   || (rr_d[1]   != rr_d[2]);
    vote_err[1] = (lock_d[0] != lock_d[1]) || (lock_d[1] != lock_d[2]);
    vote_err[2] = (lsel_d[0] != lsel_d[1]) || (lsel_d[1] != lsel_d[2]);
    vote_err[3] = (cnt_d[0]  != cnt_d[1])  || (cnt_d[1]  != cnt_d[2]);
    vote_err[4] = (wptr_d[0] != wptr_d[1]) || (wptr_d[1] != wptr_d[2]);
    vote_err[5] = (rptr_d[0] != rptr_d[1]) || (rptr_d[1] != rptr_d[2]);
    vote_err[6] = (fifo_d[0] != fifo_d[1]) || (fifo_d[1] != fifo_d[2]);
  end

  assign fault_o = |vote_err;
`else
  assign fault_o = 1'b0;
`endif

  // ---- State registers: every replica reloads the voted value ----
  always_ff @(posedge clk_i) begin
    // Port indices in the FIFO and the locked port are only meaningful
    // under cnt/lock, so they need no reset.
    lsel_q <= {3{lsel_v}};
    fifo_q <= {3{fifo_v}};
    if (rst_i) begin
      rr_q   <= '0;
      lock_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      rr_q   <= {3{rr_v}};
      lock_q <= {3{lock_v}};
      cnt_q  <= {3{cnt_v}};
      wptr_q <= {3{wptr_v}};
      rptr_q <= {3{rptr_v}};
    end
  end

  // ---- Output muxing ----
  always_comb begin
    mgr_port_req_o        = sbr_ports_req_i[sel_v];
    mgr_port_req_o.req    = mreq;
    mgr_port_req_o.rready = mgr_rready;
    for (int k = 0; k < int'(NumSbrPorts); k++) begin
      // The read payload is broadcast; only the replica strobes are steered.
      sbr_ports_rsp_o[k] = mgr_port_rsp_i;
      for (int r = 0; r < 3; r++) begin
        sbr_ports_rsp_o[k].gnt[r]    = hs[r]   && (sel[r]  == SelW'(k));
        sbr_ports_rsp_o[k].rvalid[r] = rvld[r] && (head[r] == SelW'(k));
      end
    end
  end

endmodule

// File: tb/tb_relobi_mux.sv
module tb_relobi_mux;
  import obi_pkg::*;

  localparam int NPORTS = 2;
  localparam int NMAX   = 4;

`ifdef RELOBI_MUX_FAULT_REPORT_EN
  localparam logic EXP_FAULT = 1'b1;
`else
  localparam logic EXP_FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  relobi_req_t sbr_req [NPORTS];
  relobi_rsp_t sbr_rsp [NPORTS];
  relobi_req_t mgr_req;
  relobi_rsp_t mgr_rsp;
  logic        fault;

  relobi_mux #(
    .NumSbrPorts(NPORTS),
    .NumMaxTrans(NMAX)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .sbr_ports_req_i(sbr_req),
    .sbr_ports_rsp_o(sbr_rsp),
    .mgr_port_req_o (mgr_req),
    .mgr_port_rsp_i (mgr_rsp),
    .fault_o        (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: arbitration pointer, locked port (-1 none), and the
  // ordered list of ports with a transaction in flight.
  int m_rr;
  int m_lock;
  int mq[$];

  // Expected and observed values of the most recent cycle.
  int   exp_gp, exp_rp;
  logic exp_mreq;
  int   exp_sel;
  logic exp_rdy_chk;
  logic exp_rdy;
  int   obs_gp, obs_rp;
  logic obs_mreq;
  int   obs_addr;
  logic obs_cons;
  logic obs_bcast;
  logic obs_rdy;
  logic obs_fault;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Drive one cycle of inputs, sample outputs mid-cycle, advance the model.
  task automatic step(input logic [1:0] rq, input logic g, input logic rv,
                      input logic [1:0] rdy, input logic rst, input logic inject);
    int          sel;
    logic [31:0] tmp;
    @(negedge clk);
    rst_i = rst;
    for (int k = 0; k < NPORTS; k++) begin
      tmp                  = $urandom();
      sbr_req[k].req       = {3{rq[k]}};
      sbr_req[k].rready    = {3{rdy[k]}};
      sbr_req[k].a.addr    = {tmp[23:0], 8'(k)};
      sbr_req[k].a.we      = tmp[31];
      sbr_req[k].a.be      = tmp[27:24];
      sbr_req[k].a.wdata   = $urandom();
    end
    mgr_rsp.gnt     = {3{g}};
    mgr_rsp.rvalid  = {3{rv}};
    mgr_rsp.r.rdata = $urandom();
    mgr_rsp.r.err   = 1'($urandom_range(0, 1));
    if (inject) force dut.rr_q = 3'b010;
    #1;
    obs_gp = -1; obs_rp = -1; obs_cons = 1'b1; obs_bcast = 1'b1;
    for (int k = 0; k < NPORTS; k++) begin
      if (maj3(sbr_rsp[k].gnt))    obs_gp = (obs_gp == -1) ? k : -2;
      if (maj3(sbr_rsp[k].rvalid)) obs_rp = (obs_rp == -1) ? k : -2;
      if (sbr_rsp[k].gnt != 3'b000 && sbr_rsp[k].gnt != 3'b111)       obs_cons = 1'b0;
      if (sbr_rsp[k].rvalid != 3'b000 && sbr_rsp[k].rvalid != 3'b111) obs_cons = 1'b0;
      if (sbr_rsp[k].r !== mgr_rsp.r) obs_bcast = 1'b0;
    end
    if (mgr_req.req != 3'b000 && mgr_req.req != 3'b111) obs_cons = 1'b0;
    obs_mreq  = maj3(mgr_req.req);
    obs_addr  = int'(mgr_req.a.addr[7:0]);
    obs_rdy   = maj3(mgr_req.rready);
    obs_fault = fault;
    if (inject) release dut.rr_q;

    sel = -1;
    if (m_lock >= 0) sel = m_lock;
    else
      for (int off = 0; off < NPORTS; off++)
        if (sel < 0 && rq[(m_rr + off) % NPORTS]) sel = (m_rr + off) % NPORTS;
    exp_sel     = sel;
    exp_mreq    = (sel >= 0) && (mq.size() < NMAX) && rq[sel];
    exp_gp      = (exp_mreq && g) ? sel : -1;
    exp_rp      = (rv && mq.size() > 0) ? mq[0] : -1;
    exp_rdy_chk = (mq.size() > 0);
    exp_rdy     = exp_rdy_chk ? rdy[mq[0]] : 1'b0;
    if (rst) begin
      mq.delete();
      m_rr   = 0;
      m_lock = -1;
    end else begin
      if (exp_rp >= 0 && rdy[exp_rp]) void'(mq.pop_front());
      if (exp_gp >= 0) begin
        mq.push_back(sel);
        m_rr   = (sel + 1) % NPORTS;
        m_lock = -1;
      end else if (exp_mreq) begin
        m_lock = sel;
      end
    end
  endtask

  task automatic do_reset();
    step(2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    step(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_mreq !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%0b want=0", obs_mreq); end
    total++; if (obs_gp !== -1)     begin bad++; $display("FAIL reset_gnt got=%0d want=-1", obs_gp); end
    total++; if (obs_rp !== -1)     begin bad++; $display("FAIL reset_rvalid got=%0d want=-1", obs_rp); end
    total++; if (obs_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", obs_fault); end
    // A response with nothing outstanding must not reach any port.
    step(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (obs_rp !== -1)     begin bad++; $display("FAIL reset_stray_rvalid got=%0d want=-1", obs_rp); end
    total++; if (obs_gp !== -1)     begin bad++; $display("FAIL reset_idle_gnt got=%0d want=-1", obs_gp); end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      total++; if (obs_gp !== i % 2) begin bad++; $display("FAIL alt_gnt[%0d] got=%0d want=%0d", i, obs_gp, i % 2); end
      total++; if (obs_addr !== i % 2) begin bad++; $display("FAIL alt_addr[%0d] got=%0d want=%0d", i, obs_addr, i % 2); end
    end
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
      total++;
      if (obs_rp !== ((i < 4) ? i % 2 : -1)) begin
        bad++; $display("FAIL alt_rsp[%0d] got=%0d want=%0d", i, obs_rp, (i < 4) ? i % 2 : -1);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    step(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_mreq !== 1'b1) begin bad++; $display("FAIL lock_req got=%0b want=1", obs_mreq); end
    total++; if (obs_addr !== 1)    begin bad++; $display("FAIL lock_addr0 got=%0d want=1", obs_addr); end
    for (int i = 0; i < 2; i++) begin
      step(2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
      total++; if (obs_addr !== 1) begin bad++; $display("FAIL lock_addr_hold[%0d] got=%0d want=1", i, obs_addr); end
      total++; if (obs_gp !== -1)  begin bad++; $display("FAIL lock_nognt[%0d] got=%0d want=-1", i, obs_gp); end
    end
    step(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 1) begin bad++; $display("FAIL lock_gnt got=%0d want=1", obs_gp); end
    step(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 0) begin bad++; $display("FAIL lock_next got=%0d want=0", obs_gp); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < NMAX; i++) begin
      step(2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      total++; if (obs_gp !== 0) begin bad++; $display("FAIL full_fill[%0d] got=%0d want=0", i, obs_gp); end
    end
    step(2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== -1)     begin bad++; $display("FAIL full_block got=%0d want=-1", obs_gp); end
    total++; if (obs_mreq !== 1'b0) begin bad++; $display("FAIL full_mreq got=%0b want=0", obs_mreq); end
    step(2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== -1) begin bad++; $display("FAIL full_pop_block got=%0d want=-1", obs_gp); end
    total++; if (obs_rp !== 0)  begin bad++; $display("FAIL full_pop_rsp got=%0d want=0", obs_rp); end
    step(2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 0) begin bad++; $display("FAIL full_after_pop got=%0d want=0", obs_gp); end
  endtask

  task automatic test_push_pop();
    do_reset();
    step(2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 1) begin bad++; $display("FAIL pp_g1 got=%0d want=1", obs_gp); end
    step(2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 0) begin bad++; $display("FAIL pp_g0 got=%0d want=0", obs_gp); end
    step(2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 0) begin bad++; $display("FAIL pp_both_gnt got=%0d want=0", obs_gp); end
    total++; if (obs_rp !== 1) begin bad++; $display("FAIL pp_both_rsp got=%0d want=1", obs_rp); end
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
      total++;
      if (obs_rp !== ((i < 2) ? 0 : -1)) begin
        bad++; $display("FAIL pp_drain[%0d] got=%0d want=%0d", i, obs_rp, (i < 2) ? 0 : -1);
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    step(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    total++; if (obs_gp !== 0)         begin bad++; $display("FAIL fault_arb got=%0d want=0", obs_gp); end
    total++; if (obs_addr !== 0)       begin bad++; $display("FAIL fault_addr got=%0d want=0", obs_addr); end
    total++; if (obs_fault !== EXP_FAULT) begin bad++; $display("FAIL fault_flag got=%0b want=%0b", obs_fault, EXP_FAULT); end
    step(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (dut.rr_q !== {3{1'(m_rr)}}) begin bad++; $display("FAIL fault_repair got=%b want=%b", dut.rr_q, {3{1'(m_rr)}}); end
    total++; if (obs_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%0b want=0", obs_fault); end
    step(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    total++; if (obs_gp !== 1) begin bad++; $display("FAIL fault_next got=%0d want=1", obs_gp); end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (obs_rp !== -1) begin bad++; $display("FAIL mr_rsp got=%0d want=-1", obs_rp); end
    for (int i = 0; i < NMAX + 1; i++) begin
      step(2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      total++;
      if (obs_gp !== ((i < NMAX) ? 1 : -1)) begin
        bad++; $display("FAIL mr_capacity[%0d] got=%0d want=%0d", i, obs_gp, (i < NMAX) ? 1 : -1);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] rq, rdy;
    logic       g, rv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rq  = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      g   = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      step(rq, g, rv, rdy, 1'b0, 1'b0);
      total++; if (obs_gp !== exp_gp)     begin bad++; $display("FAIL rnd_gnt[%0d] got=%0d want=%0d", i, obs_gp, exp_gp); end
      total++; if (obs_rp !== exp_rp)     begin bad++; $display("FAIL rnd_rsp[%0d] got=%0d want=%0d", i, obs_rp, exp_rp); end
      total++; if (obs_mreq !== exp_mreq) begin bad++; $display("FAIL rnd_mreq[%0d] got=%0b want=%0b", i, obs_mreq, exp_mreq); end
      total++; if (obs_cons !== 1'b1)     begin bad++; $display("FAIL rnd_replicas[%0d] got=%0b want=1", i, obs_cons); end
      total++; if (obs_bcast !== 1'b1)    begin bad++; $display("FAIL rnd_rbcast[%0d] got=%0b want=1", i, obs_bcast); end
      total++; if (obs_fault !== 1'b0)    begin bad++; $display("FAIL rnd_fault[%0d] got=%0b want=0", i, obs_fault); end
      if (exp_mreq) begin
        total++; if (obs_addr !== exp_sel) begin bad++; $display("FAIL rnd_addr[%0d] got=%0d want=%0d", i, obs_addr, exp_sel); end
      end
      if (exp_rdy_chk) begin
        total++; if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rready[%0d] got=%0b want=%0b", i, obs_rdy, exp_rdy); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    mgr_rsp = '0;
    for (int k = 0; k < NPORTS; k++) sbr_req[k] = '0;
    m_rr   = 0;
    m_lock = -1;
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_push_pop();
    test_fault();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
